// File: rtl/codebook_loader.sv
// codebook_loader: reads the initial SOM codebook out of RAM_W and streams it to the
// VEP weight registers as indexed load strobes, one entry per cycle.
module codebook_loader #(
    parameter int N_ENTRIES = 64,
    parameter int BASE_ADDR = 0,
    parameter int RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [23:0] RAM_W_Q,
    output logic        RAM_W_OE,
    output logic [17:0] RAM_W_A,
    output logic        load_valid,
    output logic [5:0]  load_idx,
    output logic [23:0] load_data,
    output logic        busy,
    output logic        load_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [5:0]  LAST_IDX = 6'(N_ENTRIES - 1);
    localparam logic [17:0] BASE     = 18'(BASE_ADDR);

    state_t            state;
    state_t            state_next;
    logic [5:0]        k;                    // index of the address currently on RAM_W_A
    logic [RD_LAT-1:0] issued;               // one bit per read still travelling through the SRAM
    logic [5:0]        idx_pipe [RD_LAT];    // index travelling alongside each issued bit
    logic              last_delivered;

    // The final entry is on the load bus this cycle, so the codebook is complete.
    assign last_delivered = load_valid && (load_idx == LAST_IDX);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: every flop is written with <= so all registers update from pre-edge values;
        // a blocking = here would let later blocks see the new state within the same edge.
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort takes priority over every other event outside IDLE.
    always_comb begin
        // NOTE: defaulting state_next before the case keeps every path assigned, so no latch.
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_next = S_READ;
                end
            end
            S_READ: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (k == LAST_IDX) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (last_delivered) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output decode: OE only while addresses are issued, busy from READ through DONE.
    always_comb begin
        RAM_W_OE  = 1'b0;
        busy      = 1'b0;
        load_done = 1'b0;
        case (state)
            S_READ: begin
                RAM_W_OE = 1'b1;
                busy     = 1'b1;
            end
            S_DRAIN: begin
                busy = 1'b1;
            end
            S_DONE: begin
                busy      = 1'b1;
                load_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Address counter: RAM_W_A is a register so the SRAM never sees a decoded glitch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k       <= '0;
            RAM_W_A <= '0;
        end else if (state_next == S_IDLE) begin
            k       <= '0;
            RAM_W_A <= '0;
        end else if (state == S_IDLE) begin
            k       <= '0;
            RAM_W_A <= BASE;
        end else if ((state == S_READ) && (state_next == S_READ)) begin
            k       <= k + 6'd1;
            RAM_W_A <= BASE + {12'd0, k + 6'd1};
        end
    end

    // Read-tracking shift register: an issued bit and its index emerge as RAM_W_Q becomes valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issued <= '0;
            // NOTE: this small index pipeline is flops, not a RAM, so it is cleared on reset
            // like any other state; a true memory array would be left unreset.
            for (int i = 0; i < RD_LAT; i++) begin
                idx_pipe[i] <= '0;
            end
        end else if (abort) begin
            issued <= '0;
        end else begin
            issued[0]   <= RAM_W_OE;
            idx_pipe[0] <= k;
            for (int i = 1; i < RD_LAT; i++) begin
                issued[i]   <= issued[i-1];
                idx_pipe[i] <= idx_pipe[i-1];
            end
        end
    end

    // Load bus register: captures the SRAM word and its index; holds both between strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_valid <= 1'b0;
            load_idx   <= '0;
            load_data  <= '0;
        end else if (abort) begin
            load_valid <= 1'b0;
        end else begin
            load_valid <= issued[RD_LAT-1];
            if (issued[RD_LAT-1]) begin
                load_idx  <= idx_pipe[RD_LAT-1];
                load_data <= RAM_W_Q;
            end
        end
    end

endmodule
